// File: rtl/stage_7_butterfly_sequencer.sv
// stage_7_butterfly_sequencer: frame buffer and pair sequencer for the final radix-2 FFT stage
module stage_7_butterfly_sequencer #(
    parameter int DATA_W = 32,
    parameter int N      = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_re,
    input  logic [DATA_W-1:0] i_in_im,
    output logic [5:0]        o_rom_addr,
    input  logic [31:0]       i_rom_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_a_re,
    output logic [DATA_W-1:0] o_a_im,
    output logic [DATA_W-1:0] o_b_re,
    output logic [DATA_W-1:0] o_b_im,
    output logic [31:0]       o_angle,
    output logic [5:0]        o_k,
    output logic              o_last,
    output logic              o_busy
);
    typedef enum logic [1:0] {LOAD, PRIME, ISSUE} state_t;

    state_t              state;
    logic [6:0]          wr_idx;
    logic [5:0]          k;
    logic [2*DATA_W-1:0] mem [N];
    logic                accept;
    logic                fire;
    logic                last_k;
    logic                load_ops;

    assign o_in_ready  = (state == LOAD);
    assign o_out_valid = (state == ISSUE);
    assign o_busy      = (state != LOAD);
    assign last_k      = (k == 6'd63);
    assign o_last      = o_out_valid & last_k;
    assign accept      = i_in_valid & o_in_ready;
    assign fire        = o_out_valid & i_out_ready;
    // Operands advance on the same edge the ROM latches the next index, keeping angle and pair aligned.
    assign o_rom_addr  = (fire & ~last_k) ? k + 6'd1 : k;
    assign load_ops    = (state == PRIME) | (fire & ~last_k);
    assign o_k         = k;
    assign o_angle     = i_rom_data;

    // Sample store; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (accept) mem[wr_idx] <= {i_in_re, i_in_im};
    end

    // Sequencer state, counters and operand registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= LOAD;
            wr_idx <= '0;
            k      <= '0;
            o_a_re <= '0;
            o_a_im <= '0;
            o_b_re <= '0;
            o_b_im <= '0;
        end else begin
            if (load_ops) begin
                {o_a_re, o_a_im} <= mem[{1'b0, o_rom_addr}];
                {o_b_re, o_b_im} <= mem[{1'b1, o_rom_addr}];
            end
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_idx <= wr_idx + 7'd1;
                        if (wr_idx == 7'd127) state <= PRIME;
                    end
                end
                PRIME: state <= ISSUE;
                ISSUE: begin
                    if (fire) begin
                        k <= last_k ? 6'd0 : k + 6'd1;
                        if (last_k) state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_7_butterfly_sequencer.sv
// tb_stage_7_butterfly_sequencer: randomized scoreboard bench for the stage-7 butterfly sequencer
module tb_stage_7_butterfly_sequencer;
    typedef struct packed {
        logic [5:0]  k;
        logic [31:0] a_re;
        logic [31:0] a_im;
        logic [31:0] b_re;
        logic [31:0] b_im;
        logic [31:0] ang;
        logic        last;
    } pair_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        i_out_ready = 1'b0;
    logic [31:0] i_in_re = '0;
    logic [31:0] i_in_im = '0;
    logic [31:0] i_rom_data = '0;
    logic        o_in_ready, o_out_valid, o_last, o_busy;
    logic [5:0]  o_rom_addr, o_k;
    logic [31:0] o_a_re, o_a_im, o_b_re, o_b_im, o_angle;

    stage_7_butterfly_sequencer #(.DATA_W(32), .N(128)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_re(i_in_re), .i_in_im(i_in_im),
        .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_a_re(o_a_re), .o_a_im(o_a_im), .o_b_re(o_b_re), .o_b_im(o_b_im),
        .o_angle(o_angle), .o_k(o_k), .o_last(o_last), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          fires = 0;
    int          bp = 0;
    int          stall_cnt = 0;
    bit          st0 = 0;
    bit          st63 = 0;
    logic [31:0] rom [64];
    logic [31:0] fr_re [128];
    logic [31:0] fr_im [128];
    pair_t       exp_q [$];

    function automatic void chk(string name, logic [199:0] act, logic [199:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endfunction

    function automatic void fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural angle ROM: registered read, one cycle latency, no enable.
    always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

    // Downstream ready: always-on, or 50% random with 10-cycle stalls at pair 0 and pair 63.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (bp == 0) i_out_ready = 1'b1;
        else if (stall_cnt > 0) begin
            i_out_ready = 1'b0;
            stall_cnt--;
        end else if (o_busy === 1'b1 && o_k == 6'd0 && !st0) begin
            st0 = 1;
            i_out_ready = 1'b0;
            stall_cnt = 9;
        end else if (o_out_valid === 1'b1 && o_k == 6'd63 && !st63) begin
            st63 = 1;
            i_out_ready = 1'b0;
            stall_cnt = 9;
        end else i_out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every fire and checks stall stability.
    pair_t cur, prev, e;
    bit    prev_stall = 0;
    always @(negedge i_clk) begin
        if (i_rst) prev_stall = 0;
        else begin
            cur = {o_k, o_a_re, o_a_im, o_b_re, o_b_im, o_angle, o_last};
            if (prev_stall) chk("stall_hold", 200'({o_out_valid, cur}), 200'({1'b1, prev}));
            if (o_busy === 1'b1) chk("in_ready_busy", 200'(o_in_ready), 200'(1'b0));
            if (o_out_valid === 1'b1 && i_out_ready === 1'b1) begin
                fires++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pair: got k=%0d want none", o_k);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", 200'(cur), 200'(e));
                end
            end
            prev_stall = (o_out_valid === 1'b1 && i_out_ready === 1'b0);
            prev = cur;
        end
    end

    task automatic load_frame(input logic [31:0] br, input logic [31:0] bi, input bit rnd,
                              input bit gaps, output int first_cyc);
        int n = 0;
        int guard = 0;
        first_cyc = 0;
        while (n < 128 && guard < 5000) begin
            @(negedge i_clk);
            guard++;
            i_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_in_re = rnd ? $urandom : br + 32'(n);
            i_in_im = rnd ? $urandom : bi + 32'(n);
            if (i_in_valid && o_in_ready) begin
                if (n == 0) first_cyc = cyc;
                fr_re[n] = i_in_re;
                fr_im[n] = i_in_im;
                n++;
            end
        end
        if (n < 128) begin
            fail_now("load_frame");
            $fatal(1, "load stuck");
        end
        for (int j = 0; j < 64; j++)
            exp_q.push_back({6'(j), fr_re[j], fr_im[j], fr_re[j+64], fr_im[j+64], rom[j], j == 63});
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b1;
        i_in_re = 32'hdeadbeef;
        i_in_im = 32'hdeadbeef;
        @(negedge i_clk);
        chk("in_ready_fall", 200'({o_in_ready, o_out_valid, o_busy}), 200'(3'b001));
        @(negedge i_clk);
        chk("valid_rise_2cyc", 200'({o_out_valid, o_k}), 200'({1'b1, 6'd0}));
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge i_clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_k(input logic [5:0] kk);
        int guard = 0;
        do begin
            @(negedge i_clk);
            guard++;
        end while (!(o_out_valid === 1'b1 && o_k == kk) && guard < 2000);
        if (guard >= 2000) fail_now("wait_k");
    endtask

    int c1, c2;
    initial begin
        for (int j = 0; j < 64; j++) rom[j] = $urandom;
        rom[0]  = 32'h00000000;
        rom[16] = 32'hbf490fdb;
        rom[63] = 32'hc045eb9b;

        // Reset takes effect mid-cycle without a clock edge.
        #12 i_rst = 1'b1;
        #1;
        chk("reset_outs", 200'({o_in_ready, o_out_valid, o_rom_addr, o_k, o_busy, o_last}),
            200'({1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0}));
        chk("reset_ops", 200'({o_a_re, o_a_im, o_b_re, o_b_im}), 200'(0));
        @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst = 1'b0;

        // Known pattern with explicit pair contents.
        bp = 0;
        load_frame(32'h0, 32'h100, 0, 0, c1);
        chk("k0", 200'({o_a_re, o_b_re, o_angle}), 200'({32'd0, 32'd64, 32'h00000000}));
        wait_k(6'd16);
        chk("k16", 200'({o_a_re, o_b_re, o_angle}), 200'({32'd16, 32'd80, 32'hbf490fdb}));
        wait_k(6'd63);
        chk("k63", 200'({o_b_im, o_angle, o_last}), 200'({32'h17f, 32'hc045eb9b, 1'b1}));
        drain();

        // Random backpressure with long stalls at both ends.
        bp = 1;
        st0 = 0;
        st63 = 0;
        fires = 0;
        load_frame(0, 0, 1, 0, c1);
        drain();
        chk("fire_count", 200'(fires), 200'(64));

        // Random input gaps, junk offered during ISSUE.
        load_frame(32'h500, 32'h600, 0, 1, c1);
        drain();

        // Mid-frame reset then reload.
        bp = 0;
        load_frame(0, 0, 1, 0, c1);
        wait_k(6'd30);
        #2 i_rst = 1'b1;
        i_in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset", 200'({o_in_ready, o_out_valid, o_k, o_busy}), 200'({1'b1, 1'b0, 6'd0, 1'b0}));
        @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        load_frame(32'h1000, 32'h2000, 0, 0, c1);
        chk("reload_k0", 200'({o_k, o_a_re}), 200'({6'd0, 32'h1000}));
        drain();

        // Back-to-back frames with input always valid.
        load_frame(0, 0, 1, 0, c1);
        load_frame(0, 0, 1, 0, c2);
        chk("period", 200'(c2 - c1), 200'(193));
        drain();

        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
